// File: rtl/dac_gen_pkg.sv
// Shared types for the DAC test-waveform generator: waveform modes and sequencer states.
package dac_gen_pkg;

   typedef enum logic [1:0] {
      SAW = 2'd0,
      TRI = 2'd1,
      SQR = 2'd2,
      MID = 2'd3
   } wave_mode_e;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WAIT   = 2'd1,
      SEND_A = 2'd2,
      SEND_B = 2'd3
   } gen_state_e;

endpackage

// File: rtl/dac_wave_gen_if.sv
// Avalon-ST sample stream carried from the generator to a two-channel DAC sink.
interface dac_wave_gen_if #(
   parameter int DATA_WIDTH = 14
);
   logic                  valid;
   logic                  channel;
   logic [DATA_WIDTH-1:0] data;
   logic                  ready;

   modport master (output valid, output channel, output data, input ready);
   modport slave  (input valid, input channel, input data, output ready);
endinterface

// File: rtl/dac_wave_chan.sv
// One waveform channel: phase counter, triangle direction, mode decode and output coding.
module dac_wave_chan
   import dac_gen_pkg::*;
#(
   parameter int DATA_WIDTH = 14,
   parameter int STEP       = 1,
   parameter bit SIGNED_OUT = 1'b0
) (
   input  logic                  csi_clk,
   input  logic                  rsi_reset,
   input  logic                  upd,
   input  wave_mode_e            mode,
   output logic [DATA_WIDTH-1:0] sample
);
   localparam logic [DATA_WIDTH-1:0] MAX_V  = '1;
   localparam logic [DATA_WIDTH-1:0] STEP_V = DATA_WIDTH'(STEP);
   localparam logic [DATA_WIDTH-1:0] MID_V  = {1'b1, {(DATA_WIDTH-1){1'b0}}};

   logic [DATA_WIDTH-1:0] cnt_q, cnt_d;
   logic                  dir_q, dir_d;
   logic [DATA_WIDTH-1:0] raw;

   always_comb begin
      cnt_d = cnt_q;
      dir_d = dir_q;
      if (upd) begin
         case (mode)
            SAW, SQR: cnt_d = cnt_q + STEP_V;
            TRI: begin
               // dir_q=1 means falling; the ends clamp rather than wrap
               if (!dir_q) begin
                  if (cnt_q > MAX_V - STEP_V) begin
                     cnt_d = MAX_V;
                     dir_d = 1'b1;
                  end else begin
                     cnt_d = cnt_q + STEP_V;
                  end
               end else begin
                  if (cnt_q < STEP_V) begin
                     cnt_d = '0;
                     dir_d = 1'b0;
                  end else begin
                     cnt_d = cnt_q - STEP_V;
                  end
               end
            end
            default: cnt_d = cnt_q;
         endcase
      end
   end

   always_comb begin
      case (mode)
         SAW, TRI: raw = cnt_q;
         SQR:      raw = cnt_q[DATA_WIDTH-1] ? MAX_V : '0;
         default:  raw = MID_V;
      endcase
      sample = SIGNED_OUT ? {~raw[DATA_WIDTH-1], raw[DATA_WIDTH-2:0]} : raw;
   end

   always_ff @(posedge csi_clk or posedge rsi_reset) begin
      if (rsi_reset) begin
         cnt_q <= '0;
         dir_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         dir_q <= dir_d;
      end
   end

endmodule

// File: rtl/dac_wave_gen.sv
// Two-channel DAC test-waveform generator emitting A/B sample pairs on an Avalon-ST source.
// state  | meaning
// IDLE   | generator stopped, no output
// WAIT   | running, waiting for the next sample tick
// SEND_A | channel A sample presented, waiting for handshake
// SEND_B | channel B sample presented, waiting for handshake
module dac_wave_gen
   import dac_gen_pkg::*;
#(
   parameter int    DATA_WIDTH = 14,
   parameter int    STEP       = 1,
   parameter int    TICK_DIV   = 100,
   parameter string SIGN_A     = "UNSIGNED",
   parameter string SIGN_B     = "UNSIGNED"
) (
   input  logic                  csi_clk,
   input  logic                  rsi_reset,
   input  logic                  coe_enable,
   input  logic [1:0]            coe_modeA,
   input  logic [1:0]            coe_modeB,
   output logic                  aso_gen_valid,
   output logic                  aso_gen_channel,
   output logic [DATA_WIDTH-1:0] aso_gen_data,
   input  logic                  aso_gen_ready,
   output logic                  coe_overrun
);
   localparam int             TW        = $clog2(TICK_DIV);
   localparam logic [TW-1:0]  TICK_LAST = TW'(TICK_DIV - 1);
   localparam bit             SGN_A     = (SIGN_A == "SIGNED");
   localparam bit             SGN_B     = (SIGN_B == "SIGNED");

   gen_state_e            state_q, state_d;
   logic [TW-1:0]         tick_cnt_q, tick_cnt_d;
   logic                  valid_q, valid_d;
   logic                  channel_q, channel_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic                  overrun_q, overrun_d;

   logic                  tick, hs, upd;
   logic [DATA_WIDTH-1:0] sample_a, sample_b;

   assign tick = coe_enable && (tick_cnt_q == TICK_LAST);
   assign hs   = valid_q && aso_gen_ready;
   assign upd  = (state_q == SEND_B) && hs;

   dac_wave_chan #(.DATA_WIDTH(DATA_WIDTH), .STEP(STEP), .SIGNED_OUT(SGN_A)) u_chan_a (
      .csi_clk   (csi_clk),
      .rsi_reset (rsi_reset),
      .upd       (upd),
      .mode      (wave_mode_e'(coe_modeA)),
      .sample    (sample_a)
   );

   dac_wave_chan #(.DATA_WIDTH(DATA_WIDTH), .STEP(STEP), .SIGNED_OUT(SGN_B)) u_chan_b (
      .csi_clk   (csi_clk),
      .rsi_reset (rsi_reset),
      .upd       (upd),
      .mode      (wave_mode_e'(coe_modeB)),
      .sample    (sample_b)
   );

   always_comb begin
      tick_cnt_d = '0;
      if (coe_enable && !tick) tick_cnt_d = tick_cnt_q + TW'(1);

      state_d   = state_q;
      valid_d   = valid_q;
      channel_d = channel_q;
      data_d    = data_q;
      overrun_d = overrun_q || (tick && (state_q != WAIT));

      case (state_q)
         IDLE: if (coe_enable) state_d = WAIT;
         WAIT: begin
            // losing enable wins over a coincident tick
            if (!coe_enable) begin
               state_d = IDLE;
            end else if (tick) begin
               state_d   = SEND_A;
               valid_d   = 1'b1;
               channel_d = 1'b0;
               data_d    = sample_a;
            end
         end
         SEND_A: if (hs) begin
            state_d   = SEND_B;
            channel_d = 1'b1;
            data_d    = sample_b;
         end
         SEND_B: if (hs) begin
            state_d = coe_enable ? WAIT : IDLE;
            valid_d = 1'b0;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge csi_clk or posedge rsi_reset) begin
      if (rsi_reset) begin
         state_q    <= IDLE;
         tick_cnt_q <= '0;
         valid_q    <= 1'b0;
         channel_q  <= 1'b0;
         data_q     <= '0;
         overrun_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         tick_cnt_q <= tick_cnt_d;
         valid_q    <= valid_d;
         channel_q  <= channel_d;
         data_q     <= data_d;
         overrun_q  <= overrun_d;
      end
   end

   assign aso_gen_valid   = valid_q;
   assign aso_gen_channel = channel_q;
   assign aso_gen_data    = data_q;
   assign coe_overrun     = overrun_q;

endmodule
